sar_search: RTL
===============

Name: sar_search

Overview:
- Successive-approximation search controller: the initiating side of the magnitude-comparator interface.
- It drives a candidate value (`trial`) into an external combinational comparator whose other operand is a hidden target. It reads back the gt/eq/lt flags and binary-searches, MSB first, for the target value.
- Sits beside the comparator in ADC-style and threshold-search datapaths. Reports the found value with a start/busy/done handshake.

Parameters:
- WIDTH, 4, width of trial/result and number of search steps (>=2).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset; sampled on rising edge of clk.
- start  input  1  request a new search; sampled only in IDLE.
- cmp_gt  input  1  comparator flag: trial > target.
- cmp_eq  input  1  comparator flag: trial == target.
- cmp_lt  input  1  comparator flag: trial < target.
- trial  output  WIDTH  registered candidate driven to the comparator A operand.
- busy  output  1  high while in SEARCH.
- done  output  1  one-cycle pulse; result valid.
- result  output  WIDTH  registered search result; holds until next done.
- protocol_err  output  1  sticky flag: comparator flags were not one-hot during a search.

Behaviour:
- Reset (rst_n=0 at edge, any state, including mid-search):
  - state=IDLE; trial=0, result=0, busy=0, done=0, protocol_err=0.
  - Internal bit index=WIDTH-1.
- States: IDLE, SEARCH, DONE.
- IDLE:
  - start=1 at an edge: trial<=1<<(WIDTH-1), idx<=WIDTH-1, protocol_err<=0, state<=SEARCH.
  - start=0: remain IDLE, trial held at 0.
- SEARCH (busy=1). At each edge, with flags produced combinationally from the current trial:
  - If cmp_gt=1, clear trial[idx]; otherwise keep it.
  - If idx>0: set trial[idx-1]=1, idx<=idx-1.
  - If idx==0: result<=adjusted trial, trial<=adjusted trial, state<=DONE.
  - Exactly WIDTH SEARCH cycles.
  - Result = largest value <= target; equals target when the comparator is honest.
- DONE: done=1 for exactly one cycle, busy=0; next edge state<=IDLE, trial<=0.
- Latency: start sampled at edge k -> done high in the cycle following edge k+WIDTH (i.e. WIDTH+1 cycles after start edge, counting the DONE cycle).
- start while SEARCH or DONE: ignored; no queuing, no restart.
- Flag check: in SEARCH, if {cmp_gt,cmp_eq,cmp_lt} is not exactly one-hot at an edge:
  - protocol_err<=1 (sticky until next accepted start).
  - The search continues, using cmp_gt alone as the decision.
- Boundaries:
  - Target 0: all trial bits cleared, result 0.
  - Target 2^WIDTH-1: all bits kept, result all-ones.
  - No arithmetic overflow is possible; trial only sets or clears single bits.
- Simultaneous rst_n=0 and start=1: reset wins.

Optional Feature:
- Macro SAR_SEARCH_EARLY_EXIT_EN.
- Defined: in SEARCH, cmp_eq=1 at an edge -> result<=trial (bit kept), trial held, state<=DONE immediately, regardless of idx.
  - Done can arrive after 1..WIDTH search cycles.
  - The protocol_err check still applies on that edge.
- Undefined: cmp_eq is used only for the one-hot check; the search always runs WIDTH cycles.

Test Plan:
- WIDTH=4, target 5: start pulse -> trial sequence 8,4,6,5; done at 4th edge after start; result=5; protocol_err=0.
- Target 0 -> trial sequence 8,4,2,1, all gt -> result=0. Target 15 -> trial sequence 8,12,14,15 -> result=15.
- start held high for the entire search, target 9 -> exactly one done pulse with result=9; a new search begins only from IDLE.
- rst_n=0 asserted at the 2nd SEARCH edge -> next cycle trial=0, busy=0, done=0; a following start with target 3 completes normally with result=3.
- Comparator forced to gt=1 and lt=1 on one SEARCH cycle -> protocol_err=1 after that edge and still 1 after done; cleared by the next accepted start.
- With SAR_SEARCH_EARLY_EXIT_EN defined, target 8 -> first trial 8, eq=1 -> done at 1st edge after start, result=8. Without the macro, the same target -> done after 4 search edges, result=8.

Source files
------------

// File: rtl/sar_search.sv
// sar_search: successive-approximation search controller.
//
// Drives a candidate value (trial) into an external combinational magnitude
// comparator whose other operand is a hidden target. It reads back the
// gt/eq/lt flags and binary-searches the target MSB first. The found value
// is reported with a start/busy/done handshake.
//
// Parameters:
//   WIDTH         width of trial/result and number of search steps (>= 2)
//
// Ports:
//   clk           clock, rising-edge active
//   rst_n         synchronous active-low reset
//   start         request a new search (sampled only in IDLE)
//   cmp_gt        comparator flag: trial >  target
//   cmp_eq        comparator flag: trial == target
//   cmp_lt        comparator flag: trial <  target
//   trial         registered candidate driven to the comparator
//   busy          high while searching
//   done          one-cycle pulse, result valid
//   result        registered search result, held until the next done
//   protocol_err  sticky: comparator flags were not one-hot during a search
//
// Optional feature (compile-time macro SAR_SEARCH_EARLY_EXIT_EN):
//   When defined, cmp_eq=1 during a search ends it immediately with
//   result = trial. When undefined, cmp_eq only takes part in the one-hot
//   check and every search runs WIDTH steps.

module sar_search #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             cmp_gt,
   input  logic             cmp_eq,
   input  logic             cmp_lt,
   output logic [WIDTH-1:0] trial,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             protocol_err
);

   localparam int IDX_W = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

   state_t            state, state_nx;
   logic [WIDTH-1:0]  trial_nx;
   logic [WIDTH-1:0]  result_nx;
   logic [WIDTH-1:0]  adj;
   logic [IDX_W-1:0]  idx, idx_nx;
   logic              perr_nx;
   logic              flags_ok;

   assign flags_ok = $onehot({cmp_gt, cmp_eq, cmp_lt});
   assign busy     = (state == SEARCH);
   assign done     = (state == DONE);

   always_comb begin
      state_nx  = state;
      trial_nx  = trial;
      result_nx = result;
      idx_nx    = idx;
      perr_nx   = protocol_err;
      adj       = trial;

      case (state)
         IDLE: begin
            trial_nx = '0;
            if (start) begin
               trial_nx[WIDTH-1] = 1'b1;
               idx_nx            = IDX_W'(WIDTH - 1);
               perr_nx           = 1'b0;
               state_nx          = SEARCH;
            end
         end

         SEARCH: begin
            if (!flags_ok)
               perr_nx = 1'b1;
            // cmp_gt alone decides, even when the flags are malformed.
            if (cmp_gt)
               adj[idx] = 1'b0;
`ifdef SAR_SEARCH_EARLY_EXIT_EN
            if (cmp_eq) begin
               result_nx = trial;
               state_nx  = DONE;
            end else
`endif
            if (idx != '0) begin
               adj[idx - IDX_W'(1)] = 1'b1;
               trial_nx             = adj;
               idx_nx               = idx - IDX_W'(1);
            end else begin
               trial_nx  = adj;
               result_nx = adj;
               state_nx  = DONE;
            end
         end

         DONE: begin
            trial_nx = '0;
            state_nx = IDLE;
         end

         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         trial        <= '0;
         result       <= '0;
         idx          <= IDX_W'(WIDTH - 1);
         protocol_err <= 1'b0;
      end else begin
         state        <= state_nx;
         trial        <= trial_nx;
         result       <= result_nx;
         idx          <= idx_nx;
         protocol_err <= perr_nx;
      end
   end

endmodule
